// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - P6 pipeline stall and forwarding-select controller.
// Optional MDU busy interlock: MDU_STALL_EN.
module hazard_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_kind,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_md_use,
  input  logic [1:0] d_md_op,
  output logic       stall,
  output logic [2:0] cmpa_for,
  output logic [2:0] cmpb_for,
  output logic [2:0] ra_for,
  output logic [2:0] alua_for,
  output logic [2:0] alub_for,
  output logic [2:0] dmwd_for
);

  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_LOAD = 2'b01;
  localparam logic [1:0] K_LINK = 2'b10;
  localparam logic [1:0] K_MDM  = 2'b11;

  logic [4:0] e_rs_q, e_rt_q, e_a3_q, m_rt_q, m_a3_q, w_a3_q;
  logic [4:0] e_rs_d, e_rt_d, e_a3_d;
  logic [1:0] e_kind_q, m_kind_q, w_kind_q, e_kind_d;
  logic       md_stall;

  function automatic logic [1:0] tnew_e(input logic [1:0] kind);
    case (kind)
      K_LOAD:  return 2'd2;
      K_LINK:  return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  // Only a load still in M has a nonzero Tnew (1), so it blocks Tuse 0 alone.
  function automatic logic reg_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] ea3, input logic [1:0] ekind,
                                     input logic [4:0] ma3, input logic [1:0] mkind);
    logic hit_e, hit_m;
    hit_e = (src == ea3) && (tnew_e(ekind) > tuse);
    hit_m = (src == ma3) && (mkind == K_LOAD) && (tuse == 2'd0);
    return (tuse != 2'd3) && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  function automatic logic [2:0] m_code(input logic [1:0] kind);
    case (kind)
      K_ALU:   return 3'b001;
      K_MDM:   return 3'b011;
      K_LINK:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] d_fwd(input logic [4:0] src,
                                       input logic [4:0] ea3, input logic [1:0] ekind,
                                       input logic [4:0] ma3, input logic [1:0] mkind,
                                       input logic [4:0] wa3, input logic [1:0] wkind);
    if (src == 5'd0)      return 3'b000;
    else if (src == ea3)  return (ekind == K_LINK) ? 3'b100 : 3'b000;
    else if (src == ma3)  return m_code(mkind);
    else if (src == wa3)  return (wkind == K_LINK) ? 3'b110 : 3'b000;
    else                  return 3'b000;
  endfunction

  // The M producer is the newest value for an E consumer, even when it is a load.
  function automatic logic [2:0] e_fwd(input logic [4:0] src,
                                       input logic [4:0] ma3, input logic [1:0] mkind,
                                       input logic [4:0] wa3);
    if (src == 5'd0)      return 3'b000;
    else if (src == ma3)  return m_code(mkind);
    else if (src == wa3)  return 3'b010;
    else                  return 3'b000;
  endfunction

`ifdef MDU_STALL_EN
  logic [1:0] e_md_q, e_md_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_q == 2'b01)       md_cnt_d = 4'(MULT_CYCLES);
    else if (e_md_q != 2'b00)  md_cnt_d = 4'(DIV_CYCLES);
    else if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
    md_stall = d_md_use && ((e_md_q != 2'b00) || (md_cnt_q != 4'd0));
    e_md_d   = stall ? 2'b00 : d_md_op;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_q   <= 2'b00;
      md_cnt_q <= 4'd0;
    end else begin
      e_md_q   <= e_md_d;
      md_cnt_q <= md_cnt_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{d_md_use, d_md_op};
  assign md_stall  = 1'b0;
`endif

  always_comb begin
    stall = reg_stall(d_rs, d_tuse_rs, e_a3_q, e_kind_q, m_a3_q, m_kind_q)
          | reg_stall(d_rt, d_tuse_rt, e_a3_q, e_kind_q, m_a3_q, m_kind_q)
          | md_stall;
    cmpa_for = d_fwd(d_rs, e_a3_q, e_kind_q, m_a3_q, m_kind_q, w_a3_q, w_kind_q);
    cmpb_for = d_fwd(d_rt, e_a3_q, e_kind_q, m_a3_q, m_kind_q, w_a3_q, w_kind_q);
    ra_for   = cmpa_for;
    alua_for = e_fwd(e_rs_q, m_a3_q, m_kind_q, w_a3_q);
    alub_for = e_fwd(e_rt_q, m_a3_q, m_kind_q, w_a3_q);
    dmwd_for = ((m_rt_q != 5'd0) && (m_rt_q == w_a3_q)) ? 3'b010 : 3'b000;
    e_rs_d   = stall ? 5'd0 : d_rs;
    e_rt_d   = stall ? 5'd0 : d_rt;
    e_a3_d   = stall ? 5'd0 : d_a3;
    e_kind_d = stall ? K_ALU : d_kind;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_a3_q   <= 5'd0;
      e_kind_q <= K_ALU;
      m_rt_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_kind_q <= K_ALU;
      w_a3_q   <= 5'd0;
      w_kind_q <= K_ALU;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_a3_q   <= e_a3_d;
      e_kind_q <= e_kind_d;
      m_rt_q   <= e_rt_q;
      m_a3_q   <= e_a3_q;
      m_kind_q <= e_kind_q;
      w_a3_q   <= m_a3_q;
      w_kind_q <= m_kind_q;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - randomized and directed checks of hazard_unit against a stage-table model.
module tb_hazard_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_kind, d_tuse_rs, d_tuse_rt, d_md_op;
  logic       d_md_use;
  logic       stall;
  logic [2:0] cmpa_for, cmpb_for, ra_for, alua_for, alub_for, dmwd_for;

  int n_cmp = 0;
  int n_fail = 0;

  hazard_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_a3(d_a3), .d_kind(d_kind),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_md_use(d_md_use), .d_md_op(d_md_op),
    .stall(stall), .cmpa_for(cmpa_for), .cmpb_for(cmpb_for), .ra_for(ra_for),
    .alua_for(alua_for), .alub_for(alub_for), .dmwd_for(dmwd_for)
  );

  always #5 clk = ~clk;

  // Stage table: index 0 = E, 1 = M, 2 = W.
  typedef struct packed {
    logic [4:0] rs, rt, a3;
    logic [1:0] kind, md;
  } ent_t;
  ent_t st [3];
  int   cyc = 0;
  int   mdu_ready = 0;

  function automatic int tnew(int kind, int stage);
    int base;
    base = (kind == 1) ? 2 : ((kind == 2) ? 0 : 1);
    return (base > stage) ? base - stage : 0;
  endfunction

  function automatic logic [2:0] src_code(int stage, int kind);
    if (kind == 2) return 3'(4 + stage);
    if (stage == 1 && kind == 0) return 3'd1;
    if (stage == 1 && kind == 3) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [2:0] exp_d(logic [4:0] a);
    if (a == 0) return 3'd0;
    for (int k = 0; k < 3; k++)
      if (st[k].a3 == a) return src_code(k, int'(st[k].kind));
    return 3'd0;
  endfunction

  function automatic logic [2:0] exp_e(logic [4:0] a);
    if (a == 0) return 3'd0;
    if (st[1].a3 == a) return src_code(1, int'(st[1].kind));
    if (st[2].a3 == a) return 3'd2;
    return 3'd0;
  endfunction

  function automatic logic exp_stall();
    logic s;
    logic [4:0] srcs [2];
    int tuses [2];
    s = 1'b0;
    srcs[0] = d_rs; srcs[1] = d_rt;
    tuses[0] = int'(d_tuse_rs); tuses[1] = int'(d_tuse_rt);
    for (int i = 0; i < 2; i++)
      if (tuses[i] != 3 && srcs[i] != 0)
        for (int k = 0; k < 2; k++)
          if (st[k].a3 == srcs[i] && tnew(int'(st[k].kind), k) > tuses[i]) s = 1'b1;
`ifdef MDU_STALL_EN
    if (d_md_use && (st[0].md != 0 || cyc < mdu_ready)) s = 1'b1;
`endif
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) st[k] = '0;
      mdu_ready = 0;
    end else begin
      logic s;
      s = exp_stall();
      if (st[0].md != 0) mdu_ready = cyc + 1 + ((st[0].md == 2'd1) ? MULT_N : DIV_N);
      st[2] = st[1];
      st[1] = st[0];
      st[0] = s ? '0 : {d_rs, d_rt, d_a3, d_kind, d_md_op};
    end
    cyc = cyc + 1;
  end

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("stall", int'(stall), int'(exp_stall()));
    check("cmpa_for", int'(cmpa_for), int'(exp_d(d_rs)));
    check("cmpb_for", int'(cmpb_for), int'(exp_d(d_rt)));
    check("ra_for", int'(ra_for), int'(exp_d(d_rs)));
    check("alua_for", int'(alua_for), int'(exp_e(st[0].rs)));
    check("alub_for", int'(alub_for), int'(exp_e(st[0].rt)));
    check("dmwd_for", int'(dmwd_for),
          int'((st[1].rt != 0 && st[1].rt == st[2].a3) ? 3'd2 : 3'd0));
  end

  task automatic set_d(int rs, int rt, int a3, int kind, int tur, int tut, int mu, int mo);
    d_rs = 5'(rs); d_rt = 5'(rt); d_a3 = 5'(a3); d_kind = 2'(kind);
    d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut); d_md_use = mu[0]; d_md_op = 2'(mo);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    set_d(0, 0, 0, 0, 3, 3, 0, 0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look();
      check("rst_stall", int'(stall), 0);
      check("rst_selects", int'({cmpa_for, cmpb_for, ra_for, alua_for, alub_for, dmwd_for}), 0);
      step();
    end

    set_d(0, 0, 3, 1, 3, 3, 0, 0); step();
    set_d(3, 0, 0, 0, 0, 3, 0, 0);
    look(); check("lu_stall1", int'(stall), 1); step();
    look(); check("lu_stall2", int'(stall), 1); step();
    look(); check("lu_release", int'(stall), 0); check("lu_cmpa_w", int'(cmpa_for), 0);
    step();

    set_d(0, 0, 5, 0, 3, 3, 0, 0); step();
    set_d(5, 0, 0, 0, 1, 3, 0, 0); step();
    set_d(0, 0, 0, 0, 3, 3, 0, 0);
    look(); check("alu_m_alua", int'(alua_for), 1); step();
    set_d(0, 0, 6, 0, 3, 3, 0, 0); step();
    set_d(0, 0, 0, 0, 3, 3, 0, 0); step();
    set_d(6, 0, 0, 0, 1, 3, 0, 0); step();
    set_d(0, 0, 0, 0, 3, 3, 0, 0);
    look(); check("alu_w_alua", int'(alua_for), 2); step();

    set_d(0, 0, 31, 2, 3, 3, 0, 0); step();
    set_d(31, 0, 0, 0, 0, 3, 0, 0);
    look(); check("jr_ra_e", int'(ra_for), 4); check("jr_stall_e", int'(stall), 0); step();
    look(); check("jr_ra_m", int'(ra_for), 5); check("jr_stall_m", int'(stall), 0); step();
    look(); check("jr_ra_w", int'(ra_for), 6); step();

    set_d(0, 0, 8, 1, 3, 3, 0, 0); step();
    set_d(0, 8, 0, 0, 3, 2, 0, 0);
    look(); check("sw_stall", int'(stall), 0); step();
    set_d(0, 0, 0, 0, 3, 3, 0, 0); step();
    look(); check("sw_dmwd", int'(dmwd_for), 2);
    set_d(0, 0, 0, 1, 3, 3, 0, 0); step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    look(); check("zero_stall", int'(stall), 0); check("zero_cmpa", int'(cmpa_for), 0); step();

`ifdef MDU_STALL_EN
    set_d(0, 0, 0, 0, 3, 3, 0, 0); step(); step();
    set_d(0, 0, 0, 0, 3, 3, 1, 2); step();
    set_d(0, 0, 4, 3, 3, 3, 1, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      look();
      if (!stall) break;
      n++;
      step();
    end
    check("mdu_div_stall_len", n, 1 + DIV_N);
    step();
    set_d(0, 0, 0, 0, 3, 3, 1, 2); step();
    set_d(0, 0, 4, 3, 3, 3, 1, 0);
    repeat (3) step();
    look(); check("mdu_busy4", int'(stall), 1);
    reset = 1'b1; step(); reset = 1'b0;
    look(); check("mdu_reset_clear", int'(stall), 0); step();
`endif

    for (int i = 0; i < 2000; i++) begin
      int mu;
      mu = ($urandom_range(0, 5) == 0) ? 1 : 0;
      set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            mu, (mu != 0) ? $urandom_range(0, 2) : 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;
    set_d(0, 0, 0, 0, 3, 3, 0, 0);
    step(); look();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline hazard controller for the five-stage P6 CPU.
- Tracks the destination register and result kind of every in-flight instruction in E, M and W.
- From that state it drives the stall signal and the 3-bit select codes for every forwarding mux in D, E and M.
- With the MDU option compiled in, it also interlocks multiply/divide instructions against the MDU busy window.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- d_rs, d_rt  in  5 each  source registers of the D-stage instruction
- d_a3  in  5  destination register of D instruction (0 = none)
- d_kind  in  2  result kind: 00 ALU, 01 LOAD, 10 LINK (PC8), 11 MDM (mfhi/mflo)
- d_tuse_rs, d_tuse_rt  in  2 each  Tuse 0/1/2; 3 = operand unused
- d_md_use  in  1  D instruction touches the MDU (mult/div/mf*/mt*)
- d_md_op  in  2  00 none, 01 mult/multu, 10 div/divu
- stall  out  1  freeze PC and IF/ID, insert bubble into ID/EX
- cmpa_for, cmpb_for, ra_for  out  3 each  D-stage selects for comparator A/B and jr target (rs)
- alua_for, alub_for  out  3 each  E-stage ALU operand selects
- dmwd_for  out  3  M-stage store-data select

Select encoding:
- 000 register/pipeline value
- 001 ALUResult_MEM
- 010 WD_WB
- 011 MDM_RD_MEM
- 100 PC8_EX
- 101 PC8_MEM
- 110 PC8_WB

## Operation

Internal state:
- E entry: {rs, rt, a3, kind, md_op}
- M entry: {rs, rt, a3, kind}
- W entry: {a3, kind}
- Empty entry has a3 = 0.

Tnew by stage:
- ALU and MDM: E=1, M=0, W=0.
- LOAD: E=2, M=1, W=0.
- LINK: 0 in all stages.

Stall:
- A D-source with Tuse ≠ 3 and address ≠ 0 that equals a3 of the E or M entry stalls when that producer's Tnew > Tuse.
- Stall is the OR of both D sources, plus the MDU term below.

D-stage forwarding (cmpa/cmpb/ra; rs drives cmpa and ra, rt drives cmpb):
- Sources with address 0 select 000.
- Priority E > M > W; first match wins.
- E match: LINK → 100. Any other kind is stalled; select 000.
- M match: ALU → 001, MDM → 011, LINK → 101, LOAD → 000 (stalled).
- W match: LINK → 110, otherwise 000. The GRF write-through supplies the value.

E-stage forwarding (alua from E.rs, alub from E.rt):
- M match: ALU → 001, MDM → 011, LINK → 101.
- Else W match → 010.
- Else 000.

M-stage forwarding (dmwd from M.rt): W match → 010, else 000.

Pipeline advance on every rising clk:
- W ← M, M ← E.
- E ← D fields, or a bubble (all zero) when stall = 1.

## Timing

- stall and all *_for outputs are combinational from the current state and D inputs, valid in the same cycle.
- State updates only on the rising clk edge.
- reset: all entries and the MDU counter clear on the next edge. Immediately after reset: stall = 0, all *_for = 000.
- Reset asserted mid-stall or mid-MDU-busy aborts both; stall = 0 in the following cycle.
- Simultaneous E and M matches on the same register: E wins for D consumers, M wins for E consumers (newest value).
- Writes to $0 never match.

## Configuration

MDU_STALL_EN:
- Defined:
  - 4-bit busy counter.
  - When E.md_op ≠ 00 at a clk edge, counter loads MULT_CYCLES or DIV_CYCLES. Otherwise it decrements toward 0.
  - Additional stall term: d_md_use & (E.md_op ≠ 00 | counter ≠ 0).
  - Reset clears the counter.
- Undefined:
  - Counter and md_op tracking are removed.
  - d_md_use and d_md_op are ignored; stall uses register hazards only.

## Test plan

- After reset, hold d_* at zero: stall = 0 and all selects = 000 every cycle.
- Load-use:
  - lw $3 in E (LOAD), D beq uses $3 with Tuse 0 → stall = 1 for 2 cycles.
  - Then with lw in W, cmpa_for = 000.
- ALU → ALU: addu $5 in M, E instruction reads rs = $5 → alua_for = 001. With the producer in W instead → alua_for = 010.
- jal writes $31 (LINK): next D jr $31 gives ra_for = 100, one cycle later 101, then 110; stall stays 0.
- Store data: lw $8 in W, sw $8 in M → dmwd_for = 010; $0 as source never forwards (select 000).
- MDU_STALL_EN:
  - div passes E, then D = mflo → stall = 1 for 1 + DIV_CYCLES (11) cycles, then 0.
  - Assert reset at busy cycle 4 → stall = 0 next cycle.
